// File: rtl/la_oaflt_pkg.sv
// la_oaflt shared definitions: counter sizing, depth bounds,
// and the end-of-run compare used by every channel.
package la_oaflt_pkg;

    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 255;
    localparam int CNT_MAX_W = 8;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic cnt_last(input logic [CNT_MAX_W-1:0] cnt,
                                      input int depth);
        return cnt == CNT_MAX_W'(depth - 1);
    endfunction

endpackage

// File: rtl/la_oaflt_if.sv
// la_oaflt signal bundle: filter enable, OR/AND terms in,
// filtered result and change pulse out.
interface la_oaflt_if #(
    parameter int N = 1,
    parameter int M = 3
);
    logic           en;
    logic [N*M-1:0] a;
    logic [N-1:0]   b;
    logic [N-1:0]   z;
    logic [N-1:0]   chg;

    modport master (output en, a, b, input z, chg);
    modport slave  (input en, a, b, output z, chg);
endinterface

// File: rtl/la_oaflt_ch.sv
// la_oaflt single channel: OR-AND term followed by a
// consecutive-stable-edge deglitch counter.
module la_oaflt_ch
    import la_oaflt_pkg::*;
#(
    parameter int M     = 3,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [M-1:0] a,
    input  logic         b,
    output logic         z,
    output logic         chg
);
    localparam int CW = cnt_w(DEPTH);

    logic          f;
    logic [CW-1:0] cnt;
    logic          last;

    assign f    = (|a) & b;
    assign last = cnt_last(CNT_MAX_W'(cnt), DEPTH);

    // count edges where f disagrees with z; commit after DEPTH in a row
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z   <= 1'b0;
            cnt <= '0;
            chg <= 1'b0;
        end else if (!en) begin
            chg <= 1'b0;
        end else if (f == z) begin
            cnt <= '0;
            chg <= 1'b0;
        end else if (last) begin
            z   <= f;
            cnt <= '0;
            chg <= 1'b1;
        end else begin
            cnt <= cnt + CW'(1);
            chg <= 1'b0;
        end
    end
endmodule

// File: rtl/la_oaflt.sv
// la_oaflt top: N deglitched OR-AND channels.
// Optional LA_OAFLT_SYNC_EN adds a 2-flop input synchroniser.
module la_oaflt
    import la_oaflt_pkg::*;
#(
    parameter string PROP  = "DEFAULT",
    parameter int    N     = 1,
    parameter int    M     = 3,
    parameter int    DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    la_oaflt_if.slave bus
);
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("la_oaflt: DEPTH out of range");
    end
    if (PROP == "") begin : g_bad_prop
        $error("la_oaflt: empty PROP");
    end

    logic [N*M-1:0] a_f;
    logic [N-1:0]   b_f;

`ifdef LA_OAFLT_SYNC_EN
    logic [N*M-1:0] a_s1;
    logic [N*M-1:0] a_s2;
    logic [N-1:0]   b_s1;
    logic [N-1:0]   b_s2;

    // free-running synchroniser, independent of en
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_s1 <= '0;
            a_s2 <= '0;
            b_s1 <= '0;
            b_s2 <= '0;
        end else begin
            a_s1 <= bus.a;
            a_s2 <= a_s1;
            b_s1 <= bus.b;
            b_s2 <= b_s1;
        end
    end

    assign a_f = a_s2;
    assign b_f = b_s2;
`else
    assign a_f = bus.a;
    assign b_f = bus.b;
`endif

    for (genvar i = 0; i < N; i++) begin : g_ch
        la_oaflt_ch #(
            .M     (M),
            .DEPTH (DEPTH)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .en    (bus.en),
            .a     (a_f[i*M +: M]),
            .b     (b_f[i]),
            .z     (bus.z[i]),
            .chg   (bus.chg[i])
        );
    end
endmodule

// File: tb/tb_la_oaflt.sv
// la_oaflt bench: directed plus random stimulus against a
// history-based reference model, checked through a scoreboard.
module tb_la_oaflt;
    localparam int N     = 2;
    localparam int M     = 3;
    localparam int DEPTH = 4;
`ifdef LA_OAFLT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct packed {
        logic [N-1:0] z;
        logic [N-1:0] chg;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    la_oaflt_if #(.N(N), .M(M)) bus ();

    la_oaflt #(
        .PROP  ("DEFAULT"),
        .N     (N),
        .M     (M),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] mz = '0;
    bit           hist[N][$];
    logic [N-1:0] pipe[$];

    function automatic logic [N-1:0] raw_f(input logic [N*M-1:0] av,
                                           input logic [N-1:0] bv);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            r[i] = (av[i*M +: M] != '0) && bv[i];
        return r;
    endfunction

    // Model of one rising edge: the output takes the new value once the
    // last DEPTH enabled samples all disagree with it.
    task automatic step(input logic e, input logic [N*M-1:0] av,
                        input logic [N-1:0] bv, input logic r);
        exp_t         x;
        logic [N-1:0] fs;
        bit           all_diff;
        @(negedge clk);
        bus.en = e;
        bus.a  = av;
        bus.b  = bv;
        if (r && !reset) begin
            reset = 1'b1;
            #1;
            checks++;
            if (bus.z !== '0 || bus.chg !== '0) begin
                errors++;
                $display("FAIL async_reset z=%b chg=%b want 00 00",
                         bus.z, bus.chg);
            end
        end
        reset = r;
        x.chg = '0;
        if (r) begin
            mz = '0;
            for (int i = 0; i < N; i++) hist[i].delete();
            pipe.delete();
            for (int k = 0; k < LAT; k++) pipe.push_back('0);
        end else begin
            if (LAT == 0) begin
                fs = raw_f(av, bv);
            end else begin
                pipe.push_back(raw_f(av, bv));
                fs = pipe.pop_front();
            end
            if (e) begin
                for (int i = 0; i < N; i++) begin
                    hist[i].push_back(fs[i]);
                    if (hist[i].size() > DEPTH) void'(hist[i].pop_front());
                    all_diff = (hist[i].size() == DEPTH);
                    foreach (hist[i][k])
                        if (hist[i][k] == mz[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        mz[i]    = fs[i];
                        x.chg[i] = 1'b1;
                        hist[i].delete();
                    end
                end
            end
        end
        x.z = mz;
        sb.push_back(x);
    endtask

    task automatic hold(input int n, input logic e,
                        input logic [N*M-1:0] av, input logic [N-1:0] bv);
        for (int k = 0; k < n; k++) step(e, av, bv, 1'b0);
    endtask

    // monitor: compare every post-edge output with the oldest expectation
    initial begin
        forever begin
            exp_t x;
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if (bus.z !== x.z || bus.chg !== x.chg) begin
                    errors++;
                    $display("FAIL out t=%0t z=%b chg=%b want z=%b chg=%b",
                             $time, bus.z, bus.chg, x.z, x.chg);
                end
            end
        end
    end

    initial begin
        logic [N*M-1:0] ra;
        logic [N-1:0]   rb;
        logic           re;
        bus.en = 1'b0;
        bus.a  = '0;
        bus.b  = '0;
        for (int k = 0; k < 3; k++) step(1'b1, '0, '0, 1'b1);
        hold(20, 1'b1, '0, '0);
        // channel 0 rises, channel 1 idle
        hold(10, 1'b1, 6'b000_010, 2'b01);
        step(1'b1, '0, '0, 1'b1);
        // glitch restart: 1 x3, 0 x1, 1 x6
        hold(3, 1'b1, 6'b000_001, 2'b01);
        hold(1, 1'b1, 6'b000_001, 2'b00);
        hold(6, 1'b1, 6'b000_001, 2'b01);
        // reset mid-count while z=1
        hold(2, 1'b1, 6'b000_000, 2'b01);
        step(1'b1, 6'b000_000, 2'b01, 1'b1);
        hold(8, 1'b1, 6'b000_100, 2'b01);
        step(1'b1, '0, '0, 1'b1);
        // enable freeze mid-count
        hold(2, 1'b1, 6'b000_100, 2'b01);
        hold(5, 1'b0, 6'b000_100, 2'b01);
        hold(6, 1'b1, 6'b000_100, 2'b01);
        // both channels together, then fall
        hold(8, 1'b1, 6'b111_111, 2'b11);
        hold(8, 1'b1, 6'b111_111, 2'b00);
        // random, with persistent inputs so runs complete
        ra = '0;
        rb = '0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(3) == 0) ra = N*M'($urandom);
            if ($urandom_range(3) == 0) rb = N'($urandom);
            re = ($urandom_range(7) != 0);
            step(re, ra, rb, $urandom_range(63) == 0);
        end
        hold(4, 1'b1, '0, '0);
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
